// File: rtl/sirene_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sirene_ctrl
//  Description : Alarm siren controller. Exit delay, armed watch, entry delay
//                and timed siren, with a warning buzzer during the delays and
//                a "fired since last arming" memory flag. Moore outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module sirene_ctrl #(
    parameter int T_SAIDA   = 10,
    parameter int T_ENTRADA = 8,
    parameter int T_SIRENE  = 20,
    parameter int T_BIP     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alarme_in,
    input  logic       armar,
    input  logic       desarmar,
    output logic       sirene,
    output logic       bip,
    output logic       armado,
    output logic       memoria,
    output logic [2:0] estado
);

    localparam logic [2:0] c_DESARMADO = 3'd0;
    localparam logic [2:0] c_SAIDA     = 3'd1;
    localparam logic [2:0] c_ARMADO    = 3'd2;
    localparam logic [2:0] c_ENTRADA   = 3'd3;
    localparam logic [2:0] c_DISPARADO = 3'd4;

    localparam int c_MAX_A = (T_SAIDA > T_ENTRADA) ? T_SAIDA : T_ENTRADA;
    localparam int c_MAX_B = (T_SIRENE > T_BIP) ? T_SIRENE : T_BIP;
    localparam int c_MAX   = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_CW    = $clog2(c_MAX) + 1;

    localparam logic [c_CW-1:0] c_SAIDA_END   = c_CW'(T_SAIDA - 1);
    localparam logic [c_CW-1:0] c_ENTRADA_END = c_CW'(T_ENTRADA - 1);
    localparam logic [c_CW-1:0] c_SIRENE_END  = c_CW'(T_SIRENE - 1);
    localparam logic [c_CW-1:0] c_BIP_END     = c_CW'(T_BIP - 1);
    localparam logic [c_CW-1:0] c_ONE         = c_CW'(1);

    logic            r_sync1;
    logic            r_alarme_s;
    logic [2:0]      r_estado;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] r_bip_cnt;
    logic            r_bip;
    logic            r_sirene;
    logic            r_armado;
    logic            r_memoria;

    logic [2:0]      w_next;
    logic            w_enter;
    logic            w_timed;
    logic            w_bip_state;
    logic            w_arm_ok;
    logic            w_fire;

    // Two-flop synchronizer for the asynchronous alarm condition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b0;
            r_alarme_s <= 1'b0;
        end else begin
            r_sync1    <= alarme_in;
            r_alarme_s <= r_sync1;
        end
    end

    // Next-state decode; disarm overrides everything, unused codes recover.
    always_comb begin
        w_next = r_estado;
        if (desarmar) begin
            w_next = c_DESARMADO;
        end else begin
            case (r_estado)
                c_DESARMADO: if (armar)                  w_next = c_SAIDA;
                c_SAIDA:     if (r_cnt == c_SAIDA_END)   w_next = c_ARMADO;
                c_ARMADO:    if (r_alarme_s)             w_next = c_ENTRADA;
                c_ENTRADA:   if (r_cnt == c_ENTRADA_END) w_next = c_DISPARADO;
                c_DISPARADO: if (r_cnt == c_SIRENE_END)  w_next = c_ARMADO;
                default:                                 w_next = c_DESARMADO;
            endcase
        end
    end

    // Qualifiers shared by the counters and the registered outputs.
    always_comb begin
        w_enter     = (w_next != r_estado);
        w_timed     = (r_estado == c_SAIDA) || (r_estado == c_ENTRADA) ||
                      (r_estado == c_DISPARADO);
        w_bip_state = (w_next == c_SAIDA) || (w_next == c_ENTRADA);
        w_arm_ok    = (r_estado == c_DESARMADO) && armar && !desarmar;
        w_fire      = (w_next == c_DISPARADO) && (r_estado != c_DISPARADO);
    end

    // State, timers and outputs; outputs are decoded from the next state so
    // they change together with estado on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado  <= c_DESARMADO;
            r_cnt     <= '0;
            r_bip_cnt <= '0;
            r_bip     <= 1'b0;
            r_sirene  <= 1'b0;
            r_armado  <= 1'b0;
            r_memoria <= 1'b0;
        end else begin
            r_estado <= w_next;

            // Untimed states hold the counter so it can never wrap.
            if (w_enter) begin
                r_cnt <= '0;
            end else if (w_timed) begin
                r_cnt <= r_cnt + c_ONE;
            end

            if (w_bip_state) begin
                if (w_enter) begin
                    r_bip     <= 1'b1;
                    r_bip_cnt <= '0;
                end else if (r_bip_cnt == c_BIP_END) begin
                    r_bip     <= ~r_bip;
                    r_bip_cnt <= '0;
                end else begin
                    r_bip_cnt <= r_bip_cnt + c_ONE;
                end
            end else begin
                r_bip     <= 1'b0;
                r_bip_cnt <= '0;
            end

            r_sirene <= (w_next == c_DISPARADO);
            r_armado <= (w_next != c_DESARMADO);

            if (w_fire) begin
                r_memoria <= 1'b1;
            end else if (w_arm_ok) begin
                r_memoria <= 1'b0;
            end
        end
    end

    assign estado  = r_estado;
    assign sirene  = r_sirene;
    assign bip     = r_bip;
    assign armado  = r_armado;
    assign memoria = r_memoria;

endmodule
`default_nettype wire

// File: tb/tb_sirene_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sirene_ctrl
//  Description : Self-checking bench for sirene_ctrl: vector table, directed
//                corner sequences and random stimulus against a model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sirene_ctrl;

    localparam int T_SAIDA   = 10;
    localparam int T_ENTRADA = 8;
    localparam int T_SIRENE  = 20;
    localparam int T_BIP     = 2;
    localparam int NVEC      = 42;

    logic       clk;
    logic       rst_n;
    logic       alarme_in;
    logic       armar;
    logic       desarmar;
    logic       sirene;
    logic       bip;
    logic       armado;
    logic       memoria;
    logic [2:0] estado;

    int errors;
    int checks;

    typedef struct {
        logic       arm;
        logic       dis;
        logic       al;
        logic [2:0] est;
        logic       sir;
        logic       bp;
        logic       armd;
        logic       mem;
    } vec_t;

    vec_t tbl [NVEC];

    // Behavioural model state: phase, cycles spent in phase, sync pipe, memory
    int m_st;
    int m_t;
    int m_s1;
    int m_s2;
    int m_mem;

    sirene_ctrl #(
        .T_SAIDA   (T_SAIDA),
        .T_ENTRADA (T_ENTRADA),
        .T_SIRENE  (T_SIRENE),
        .T_BIP     (T_BIP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alarme_in (alarme_in),
        .armar     (armar),
        .desarmar  (desarmar),
        .sirene    (sirene),
        .bip       (bip),
        .armado    (armado),
        .memoria   (memoria),
        .estado    (estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [2:0] e, input logic s,
                       input logic b, input logic a, input logic m);
        checks++;
        if ({estado, sirene, bip, armado, memoria} !== {e, s, b, a, m}) begin
            errors++;
            $display("FAIL %s: got est=%0d sir=%b bip=%b arm=%b mem=%b, want est=%0d sir=%b bip=%b arm=%b mem=%b",
                     nm, estado, sirene, bip, armado, memoria, e, s, b, a, m);
        end
    endtask

    // Apply inputs, take one rising edge, settle past it.
    task automatic cyc(input logic a, input logic d, input logic al);
        armar     = a;
        desarmar  = d;
        alarme_in = al;
        @(posedge clk);
        #1;
    endtask

    task automatic setv(input int i, input logic a, input logic d, input logic al,
                        input logic [2:0] e, input logic s, input logic b,
                        input logic ar, input logic m);
        tbl[i].arm = a;  tbl[i].dis = d;   tbl[i].al = al;
        tbl[i].est = e;  tbl[i].sir = s;   tbl[i].bp = b;
        tbl[i].armd = ar; tbl[i].mem = m;
    endtask

    function automatic logic bip_at(input int k);
        return ((k / T_BIP) % 2) == 0;
    endfunction

    // One clock of the model, from the rules: phase durations, 2-cycle sync
    // delay, disarm priority, memory set on firing and cleared by arming.
    task automatic model_step(input logic a, input logic d, input logic al);
        int seen;
        int ns;
        seen = m_s2;
        m_s2 = m_s1;
        m_s1 = int'(al);
        ns = m_st;
        if (d) ns = 0;
        else begin
            case (m_st)
                0: if (a) ns = 1;
                1: if (m_t == T_SAIDA) ns = 2;
                2: if (seen != 0) ns = 3;
                3: if (m_t == T_ENTRADA) ns = 4;
                4: if (m_t == T_SIRENE) ns = 2;
                default: ns = 0;
            endcase
        end
        if (ns == 4 && m_st != 4) m_mem = 1;
        else if (m_st == 0 && a && !d) m_mem = 0;
        m_t  = (ns != m_st) ? 1 : m_t + 1;
        m_st = ns;
    endtask

    initial begin
        logic a;
        logic d;
        logic al;
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        armar     = 1'b0;
        desarmar  = 1'b0;
        alarme_in = 1'b0;

        // Vector table: arming, trigger, entry delay, siren, re-arm.
        setv(0, 1, 0, 0, 3'd1, 0, 1, 1, 0);
        for (int i = 1; i < 10; i++) setv(i, 0, 0, 0, 3'd1, 0, bip_at(i), 1, 0);
        setv(10, 0, 0, 0, 3'd2, 0, 0, 1, 0);
        setv(11, 0, 0, 1, 3'd2, 0, 0, 1, 0);
        setv(12, 0, 0, 1, 3'd2, 0, 0, 1, 0);
        setv(13, 0, 0, 1, 3'd3, 0, 1, 1, 0);
        for (int i = 14; i < 21; i++) setv(i, 0, 0, 0, 3'd3, 0, bip_at(i - 13), 1, 0);
        for (int i = 21; i < 41; i++) setv(i, 0, 0, 0, 3'd4, 1, 0, 1, 1);
        setv(41, 0, 0, 0, 3'd2, 0, 0, 1, 1);

        #3;
        chk("reset", 3'd0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("reset_clocked", 3'd0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("after_release", 3'd0, 0, 0, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            cyc(tbl[i].arm, tbl[i].dis, tbl[i].al);
            chk($sformatf("vec%0d", i), tbl[i].est, tbl[i].sir, tbl[i].bp,
                tbl[i].armd, tbl[i].mem);
        end

        // Disarm in the 4th entry-delay cycle: siren must never sound.
        cyc(0, 0, 1); chk("ent_a", 3'd2, 0, 0, 1, 1);
        cyc(0, 0, 0); chk("ent_b", 3'd2, 0, 0, 1, 1);
        cyc(0, 0, 0); chk("ent_c1", 3'd3, 0, 1, 1, 1);
        cyc(0, 0, 0); chk("ent_c2", 3'd3, 0, 1, 1, 1);
        cyc(0, 0, 0); chk("ent_c3", 3'd3, 0, 0, 1, 1);
        cyc(0, 0, 0); chk("ent_c4", 3'd3, 0, 0, 1, 1);
        cyc(0, 1, 0); chk("ent_disarm", 3'd0, 0, 0, 0, 1);

        // Conflicts: disarm beats arm; accepted arm clears memory; arm ignored when armed.
        cyc(1, 1, 0); chk("arm_dis_same", 3'd0, 0, 0, 0, 1);
        cyc(1, 0, 0); chk("arm_clears_mem", 3'd1, 0, 1, 1, 0);
        for (int k = 1; k < T_SAIDA; k++) begin
            cyc(0, 0, 0); chk("saida2", 3'd1, 0, bip_at(k), 1, 0);
        end
        cyc(0, 0, 0); chk("armed2", 3'd2, 0, 0, 1, 0);
        cyc(1, 0, 0); chk("arm_ignored", 3'd2, 0, 0, 1, 0);
        cyc(0, 0, 0); chk("arm_ignored2", 3'd2, 0, 0, 1, 0);

        // Alarm held from before arming: ignored in exit delay, ARMADO for 1 cycle.
        cyc(0, 1, 1); chk("held_dis", 3'd0, 0, 0, 0, 0);
        cyc(0, 0, 1); chk("held_idle1", 3'd0, 0, 0, 0, 0);
        cyc(0, 0, 1); chk("held_idle2", 3'd0, 0, 0, 0, 0);
        cyc(1, 0, 1); chk("held_saida0", 3'd1, 0, 1, 1, 0);
        for (int k = 1; k < T_SAIDA; k++) begin
            cyc(0, 0, 1); chk("held_saida", 3'd1, 0, bip_at(k), 1, 0);
        end
        cyc(0, 0, 1); chk("held_armado", 3'd2, 0, 0, 1, 0);
        cyc(0, 0, 1); chk("held_entrada", 3'd3, 0, 1, 1, 0);
        for (int k = 1; k < T_ENTRADA; k++) cyc(0, 0, 1);
        chk("held_ent_last", 3'd3, 0, bip_at(T_ENTRADA - 1), 1, 0);
        cyc(0, 0, 1); chk("held_fire", 3'd4, 1, 0, 1, 1);
        cyc(0, 0, 1); cyc(0, 0, 1);

        // Asynchronous reset mid-siren, between clock edges.
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 3'd0, 0, 0, 0, 0);
        @(negedge clk);
        alarme_in = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("async_release", 3'd0, 0, 0, 0, 0);

        // Random stimulus against the model.
        m_st = 0; m_t = 1; m_s1 = 0; m_s2 = 0; m_mem = 0;
        al = 1'b0;
        for (int n = 0; n < 2500; n++) begin
            a = ($urandom % 6) == 0;
            d = ($urandom % 45) == 0;
            if (($urandom % 12) == 0) al = ~al;
            armar     = a;
            desarmar  = d;
            alarme_in = al;
            @(posedge clk);
            model_step(a, d, al);
            #1;
            chk($sformatf("rand%0d", n), 3'(m_st), m_st == 4,
                (m_st == 1 || m_st == 3) && bip_at(m_t - 1), m_st != 0, m_mem != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sirene_ctrl.md
SIRENE_CTRL -- requirements
Module: sirene_ctrl

Interface
REQ-001 T_SAIDA, default 10, exit-delay length in clock cycles (>=1).
REQ-002 T_ENTRADA, default 8, entry-delay length in clock cycles (>=1).
REQ-003 T_SIRENE, default 20, maximum siren-on time in clock cycles (>=1).
REQ-004 T_BIP, default 2, buzzer half-period in clock cycles (>=1).
REQ-005 clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 alarme_in  input  1  combined alarm condition from the alarm logic stage; asynchronous to clk; level-sensitive.
REQ-008 armar  input  1  arm request; synchronous single-cycle pulse.
REQ-009 desarmar  input  1  disarm request; synchronous single-cycle pulse.
REQ-010 sirene  output  1  siren drive.
REQ-011 bip  output  1  warning buzzer during exit/entry delays.
REQ-012 armado  output  1  system armed indicator.
REQ-013 memoria  output  1  alarm has fired since last arming.
REQ-014 estado  output  3  current FSM state code.

Function
REQ-015 alarme_in SHALL pass through a two-flop synchronizer; the FSM acts only on the synchronized value alarme_s.
REQ-016 FSM states/codes: DESARMADO=0, SAIDA=1, ARMADO=2, ENTRADA=3, DISPARADO=4; codes 5-7 SHALL go to DESARMADO on the next edge.
REQ-017 A single cycle counter SHALL clear on every state entry; timed states exit on the edge where counter == T_x-1, so each timed state lasts exactly T_x cycles.
REQ-018 DESARMADO: armar -> SAIDA; alarme_s ignored.
REQ-019 SAIDA: alarme_s ignored; after T_SAIDA cycles -> ARMADO.
REQ-020 ARMADO: alarme_s=1 -> ENTRADA on next edge; alarme_in rising to ENTRADA entry latency is exactly 3 edges.
REQ-021 ENTRADA: after T_ENTRADA cycles -> DISPARADO; alarme_s returning low SHALL NOT cancel.
REQ-022 DISPARADO: after T_SIRENE cycles -> ARMADO (re-arm); if alarme_s still high, REQ-020 applies.
REQ-023 desarmar SHALL force DESARMADO on the next edge from any state and wins over armar and all timers in the same cycle.
REQ-024 armar SHALL be ignored in every state except DESARMADO.
REQ-025 sirene SHALL be 1 iff estado==DISPARADO.
REQ-026 armado SHALL be 1 iff estado!=DESARMADO.
REQ-027 bip SHALL be 1 in the first cycle of SAIDA/ENTRADA, invert every T_BIP cycles while in those states, and be 0 in all other states (separate bip counter, cleared on state entry).
REQ-028 memoria SHALL set on entry to DISPARADO, hold through desarmar, and clear only on an accepted armar.
REQ-029 All outputs SHALL be registered or decoded solely from registered state (Moore); no combinational path from inputs to outputs.
REQ-030 Counter widths SHALL be $clog2 of the largest timing parameter plus 1; no wrap-around occurs in any state.

Reset
REQ-031 rst_n low SHALL immediately force estado=0, sirene=0, bip=0, armado=0, memoria=0, counters and synchronizer flops to 0, regardless of clk.
REQ-032 Reset release SHALL leave the block in DESARMADO; the first state change may occur on the first rising edge after release.

Verification
REQ-033 Arm: armar pulse at edge 0 -> estado=1, armado=1, bip=1,1,0,0,1,1,0,0,1,1 over 10 cycles, then estado=2, bip=0.
REQ-034 Trigger: in ARMADO, alarme_in high 3 cycles -> estado=3 at 3rd edge, estado=4 8 cycles later with sirene=1 and memoria=1 for 20 cycles, then estado=2, sirene=0, memoria=1.
REQ-035 Disarm during entry: desarmar at 4th ENTRADA cycle -> estado=0, bip=0, armado=0 next edge; sirene never 1.
REQ-036 Conflicts: armar+desarmar same cycle in DESARMADO -> estado stays 0; armar in ARMADO -> no change; armar after firing -> memoria=0.
REQ-037 alarme_in held high from before arming -> no effect during 10 SAIDA cycles, ARMADO for exactly 1 cycle, then ENTRADA.
REQ-038 rst_n pulsed low mid-DISPARADO between clock edges -> all outputs 0 immediately; estado=0 after release.
